// File: rtl/sram_cache_controller_pkg.sv
// Shared widths, address field helpers and FSM encoding for the
// 2-way set-associative write-through cache in front of the SRAM controller.
package sram_cache_controller_pkg;

   localparam int TAG_W   = 10;
   localparam int IDX_W   = 6;
   localparam int OFF_W   = 1;
   localparam int SETS    = 64;
   localparam int WAYS    = 2;
   localparam int WORD_W  = 32;
   localparam int BLK_W   = 64;

   localparam int OFF_LSB = 2;
   localparam int IDX_LSB = OFF_LSB + OFF_W;
   localparam int TAG_LSB = IDX_LSB + IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_MISS_READ  = 2'd1,
      ST_WRITE_THRU = 2'd2
   } state_e;

   function automatic logic [TAG_W-1:0] addr_tag(
      input logic [31:0] a
   );
      return a[TAG_LSB +: TAG_W];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(
      input logic [31:0] a
   );
      return a[IDX_LSB +: IDX_W];
   endfunction

   function automatic logic addr_word(
      input logic [31:0] a
   );
      return a[OFF_LSB];
   endfunction

   function automatic logic [WORD_W-1:0] pick_word(
      input logic [BLK_W-1:0] blk,
      input logic             sel
   );
      return sel ? blk[BLK_W-1:WORD_W] : blk[WORD_W-1:0];
   endfunction

endpackage

// File: rtl/sram_cache_controller_cache_array.sv
// Cache storage: data/tag arrays, per-way valid, per-set LRU and hit compare.
// Ports: idx/tag lookup -> hit/hit_way/hit_data; fill/touch/inval updates.
module cache_array
   import sram_cache_controller_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] idx,
   input  logic [TAG_W-1:0] tag,
   input  logic             fill_en,
   input  logic [BLK_W-1:0] fill_data,
   input  logic             touch_en,
   input  logic             inval_en,
   output logic             hit,
   output logic             hit_way,
   output logic [BLK_W-1:0] hit_data
);

   logic [BLK_W-1:0] data_q [SETS][WAYS];
   logic [BLK_W-1:0] data_d [SETS][WAYS];
   logic [TAG_W-1:0] tag_q  [SETS][WAYS];
   logic [TAG_W-1:0] tag_d  [SETS][WAYS];

   logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
   logic [SETS-1:0]           lru_q, lru_d;

   logic match0, match1;
   logic fill_way;

   assign match0 = valid_q[idx][0] && (tag_q[idx][0] == tag);
   assign match1 = valid_q[idx][1] && (tag_q[idx][1] == tag);

   // Double match cannot arise from normal fills; way0 wins if it does.
   assign hit      = match0 | match1;
   assign hit_way  = ~match0;
   assign hit_data = data_q[idx][hit_way];

   assign fill_way = lru_q[idx];

   always_comb begin
      data_d  = data_q;
      tag_d   = tag_q;
      valid_d = valid_q;
      lru_d   = lru_q;
      if (fill_en) begin
         data_d[idx][fill_way]  = fill_data;
         tag_d[idx][fill_way]   = tag;
         valid_d[idx][fill_way] = 1'b1;
         lru_d[idx]             = ~fill_way;
      end else if (touch_en && hit) begin
         lru_d[idx] = ~hit_way;
      end else if (inval_en && hit) begin
         valid_d[idx][hit_way] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         lru_q   <= '0;
      end else begin
         valid_q <= valid_d;
         lru_q   <= lru_d;
      end
   end

   // Contents are qualified by valid bits, so no reset is needed here.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      tag_q  <= tag_d;
   end

endmodule

// File: rtl/sram_cache_controller.sv
// Write-through, no-write-allocate cache controller between MEM stage and
// SRAM controller. Ports: MEM req/ready/rdata, SRAM req/ready/rdata passthru.
module sram_cache_controller
   import sram_cache_controller_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic [31:0] sram_address,
   output logic [31:0] sram_wdata,
   output logic        sram_r_en,
   output logic        sram_w_en,
   input  logic [63:0] sram_rdata,
   input  logic        sram_ready
);

   state_e state_q, state_d;

   logic             hit;
   logic             hit_way;
   logic [BLK_W-1:0] hit_data;
   logic             fill_en;
   logic             touch_en;
   logic             inval_en;
   logic             wsel;

   assign sram_address = address;
   assign sram_wdata   = wdata;
   assign wsel         = addr_word(address);

   cache_array u_array (
      .clk       (clk),
      .rst       (rst),
      .idx       (addr_idx(address)),
      .tag       (addr_tag(address)),
      .fill_en   (fill_en),
      .fill_data (sram_rdata),
      .touch_en  (touch_en),
      .inval_en  (inval_en),
      .hit       (hit),
      .hit_way   (hit_way),
      .hit_data  (hit_data)
   );

   // Outputs are gated by rst so reset takes effect without a clock.
   always_comb begin
      state_d   = state_q;
      ready     = 1'b0;
      rdata     = '0;
      sram_r_en = 1'b0;
      sram_w_en = 1'b0;
      fill_en   = 1'b0;
      touch_en  = 1'b0;
      inval_en  = 1'b0;
      if (rst) begin
         unique case (state_q)
            ST_IDLE: begin
               if (MEM_W_EN) begin
                  state_d  = ST_WRITE_THRU;
                  inval_en = 1'b1;
               end else if (MEM_R_EN) begin
                  if (hit) begin
                     ready    = 1'b1;
                     rdata    = pick_word(hit_data, wsel);
                     touch_en = 1'b1;
                  end else begin
                     state_d = ST_MISS_READ;
                  end
               end
            end
            ST_MISS_READ: begin
               sram_r_en = 1'b1;
               if (sram_ready) begin
                  ready   = 1'b1;
                  rdata   = pick_word(sram_rdata, wsel);
                  fill_en = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_WRITE_THRU: begin
               sram_w_en = 1'b1;
               if (sram_ready) begin
                  ready   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

endmodule

// File: doc/sram_cache_controller.md
SRAM_CACHE_CONTROLLER -- requirements
Module: sram_cache_controller

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-003 SHALL have port: MEM_R_EN  input  1  read request from MEM stage; level, held until ready.
REQ-004 SHALL have port: MEM_W_EN  input  1  write request from MEM stage; level, held until ready.
REQ-005 SHALL have port: address  input  32  byte address; bit[2] word select, [8:3] index, [18:9] tag; others ignored.
REQ-006 SHALL have port: wdata  input  32  store data.
REQ-007 SHALL have port: rdata  output  32  load data; valid when ready=1 and MEM_R_EN=1.
REQ-008 SHALL have port: ready  output  1  request complete; pipeline freezes while a request is pending and ready=0.
REQ-009 SHALL have port: sram_address / sram_wdata  output  32 each  address and wdata passed through unmodified.
REQ-010 SHALL have port: sram_r_en / sram_w_en  output  1 each  requests to the SRAM controller.
REQ-011 SHALL have port: sram_rdata  input  64  block from SRAM controller; [31:0] word0 (address[2]=0), [63:32] word1.
REQ-012 SHALL have port: sram_ready  input  1  one-cycle pulse: SRAM controller finished current access.

Function
REQ-013 Cache SHALL be 2-way set-associative, 64 sets, 64-bit block, 10-bit tag, one valid bit per way, one LRU bit per set (LRU=way to replace next).
REQ-014 Policy SHALL be write-through, no write-allocate.
REQ-015 FSM states SHALL be IDLE, MISS_READ, WRITE_THRU.
REQ-016 IDLE: MEM_W_EN=1 -> WRITE_THRU; else MEM_R_EN=1 and miss -> MISS_READ; else stay. MEM_W_EN has priority when both enables high.
REQ-017 Read hit in IDLE SHALL assert ready combinationally same cycle (zero-wait), rdata=hit way's word[address[2]]; LRU set to other way at posedge.
REQ-018 sram_r_en SHALL be 1 only in MISS_READ; sram_w_en only in WRITE_THRU; both 0 in IDLE (guarantees one idle cycle between SRAM accesses).
REQ-019 MISS_READ: on sram_ready=1, ready=1 same cycle, rdata=sram_rdata word[address[2]]; at posedge write block+tag into LRU way, set valid, invert LRU, go IDLE.
REQ-020 WRITE_THRU: on sram_ready=1, ready=1 same cycle; go IDLE. If address hit a way in IDLE, that way's valid SHALL be cleared on entering WRITE_THRU.
REQ-021 While sram_ready=0 in MISS_READ/WRITE_THRU, ready SHALL be 0 and state held.
REQ-022 ready SHALL be 0 in IDLE when no request or on a miss/write.
REQ-023 A tag match on both ways (illegal) SHALL select way0.
REQ-024 sram_ready received in IDLE SHALL be ignored.

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, all valid bits 0, all LRU bits 0; ready, sram_r_en, sram_w_en=0; rdata=0.
REQ-026 Reset mid-access SHALL abandon the access without filling any way; data/tag arrays need no reset.

Structure
REQ-027 Shared package SHALL hold tag/index/offset widths, set count, and FSM state encoding.
REQ-028 Storage (data, tag, valid, LRU arrays, hit/way compare) SHALL be one sub-module cache_array; FSM and muxing stay in sram_cache_controller.

Verification
REQ-029 Read 0x0000_0010 cold, sram_rdata=0x2222_2222_1111_1111 after 6 cycles -> sram_r_en held to sram_ready, ready pulse with rdata=0x1111_1111, way0 filled, LRU[2]=1.
REQ-030 Then read 0x0000_0014 -> ready same cycle, rdata=0x2222_2222, no sram_r_en.
REQ-031 Reads 0x0010, 0x0210, 0x0410 (same set 2, distinct tags) -> third miss replaces way0 (LRU); re-read 0x0210 hits, 0x0010 misses.
REQ-032 Write 0x0010 data 0xDEAD_BEEF after cached -> sram_w_en, sram_wdata=0xDEAD_BEEF, ready on sram_ready, next read 0x0010 misses.
REQ-033 rst=0 during MISS_READ -> sram_r_en drops asynchronously, later read same address misses.
REQ-034 MEM_R_EN=MEM_W_EN=1, address 0x0020 -> write path taken, sram_r_en stays 0.
